// File: rtl/panda_ex_ctrl.sv
// EX-stage pipeline controller: load-use interlock, jump/branch redirect and flush,
// multi-cycle ALU sequencing with a watchdog (compiled in only with PANDA_MULTICYCLE_EN).
module panda_ex_ctrl #(
   parameter int unsigned MaxMcCycles = 34
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [4:0]  id_rs1_addr_i,
   input  logic [4:0]  id_rs2_addr_i,
   input  logic [4:0]  ex_rd_addr_i,
   input  logic        ex_rd_we_i,
   input  logic        ex_load_i,
   input  logic        jump_i,
   input  logic        branch_i,
   input  logic        branch_cond_i,
   input  logic        mc_start_i,
   input  logic        mc_done_i,
   output logic [1:0]  pc_sel_o,
   output logic        if_id_stall_o,
   output logic        id_ex_stall_o,
   output logic        if_id_flush_o,
   output logic        id_ex_flush_o,
   output logic        mc_timeout_o,
   output logic [31:0] stall_count_o
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MC_BUSY    = 2'd2
   } state_e;

   localparam logic [1:0] PcSeq    = 2'b00;
   localparam logic [1:0] PcJump   = 2'b01;
   localparam logic [1:0] PcBranch = 2'b10;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   state_e      state_q, state_d;
   logic        load_use;
   logic        br_taken;
   logic [31:0] stall_cnt_q;

   assign load_use = ex_load_i && ex_rd_we_i && (ex_rd_addr_i != 5'd0) &&
                     ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));
   assign br_taken = branch_i && branch_cond_i;

`ifdef PANDA_MULTICYCLE_EN
   localparam logic [7:0] WdLast = 8'(MaxMcCycles - 1);

   logic [7:0] wd_q;
   logic       timeout_set;
   logic       mc_timeout_q;
   logic       mc_req;

   assign mc_req = mc_start_i && !mc_done_i;
`else
   logic unused_mc;
   assign unused_mc = mc_start_i ^ mc_done_i ^ (MaxMcCycles == 0);
`endif

   // Outputs are decoded straight from state and inputs so redirects act in the same cycle
   always_comb begin
      state_d       = state_q;
      pc_sel_o      = PcSeq;
      if_id_stall_o = 1'b0;
      id_ex_stall_o = 1'b0;
      if_id_flush_o = 1'b0;
      id_ex_flush_o = 1'b0;
`ifdef PANDA_MULTICYCLE_EN
      timeout_set   = 1'b0;
`endif
      case (state_q)
         RUN: begin
            if (jump_i) begin
               pc_sel_o      = PcJump;
               if_id_flush_o = 1'b1;
               id_ex_flush_o = 1'b1;
            end else if (br_taken) begin
               pc_sel_o      = PcBranch;
               if_id_flush_o = 1'b1;
               id_ex_flush_o = 1'b1;
            end else if (load_use) begin
               if_id_stall_o = 1'b1;
               id_ex_flush_o = 1'b1;
               state_d       = LOAD_STALL;
`ifdef PANDA_MULTICYCLE_EN
            end else if (mc_req) begin
               if_id_stall_o = 1'b1;
               id_ex_stall_o = 1'b1;
               state_d       = MC_BUSY;
`endif
            end
         end
         LOAD_STALL: state_d = RUN;
`ifdef PANDA_MULTICYCLE_EN
         MC_BUSY: begin
            if (mc_done_i) begin
               state_d = RUN;
            end else if (wd_q == WdLast) begin
               timeout_set = 1'b1;
               state_d     = RUN;
            end else begin
               if_id_stall_o = 1'b1;
               id_ex_stall_o = 1'b1;
            end
         end
`endif
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= RUN;
         stall_cnt_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (if_id_stall_o) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
         end
      end
   end

`ifdef PANDA_MULTICYCLE_EN
   // Watchdog restarts from zero whenever EX is not busy, so MC_BUSY entry sees 0
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wd_q         <= 8'd0;
         mc_timeout_q <= 1'b0;
      end else begin
         mc_timeout_q <= timeout_set;
         if (state_q == MC_BUSY) begin
            wd_q <= wd_q + 8'd1;
         end else begin
            wd_q <= 8'd0;
         end
      end
   end

   assign mc_timeout_o = mc_timeout_q;
`else
   assign mc_timeout_o = 1'b0;
`endif

   assign stall_count_o = stall_cnt_q;

endmodule
